bram_reader: RTL and testbench

Read-side sequencer for the dual-port block RAM. On a start pulse it issues a run of consecutive reads on the RAM read port (one-cycle registered read latency), absorbs that latency in a two-entry output FIFO, and presents the words as a valid/ready stream with a last marker. It is the consumer counterpart of the RAM write path: it empties buffers that other logic fills through the write port.

---
 rtl/bram_reader.sv | 145 ++++++++++++++
 tb/tb_bram_reader.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/bram_reader.sv
// Read-side sequencer for the dual-port block RAM: issues a run of
// consecutive reads, absorbs the one-cycle read latency in a two-entry
// FIFO, and presents the words as a valid/ready stream with a last marker.
module bram_reader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              r_en,
  output logic [ADDR_W-1:0] r_addr,
  input  logic [DATA_W-1:0] r_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;       // next address to read
  logic [ADDR_W-1:0] last_addr_q;  // address of the most recent read
  logic [ADDR_W:0]   issue_rem_q;
  logic [ADDR_W:0]   out_rem_q;
  logic              inflight_q;
  logic              done_q, done_d;
  logic              issue;

  logic [DATA_W-1:0] fifo_mem [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q;
  logic              pop;
  logic [2:0]        occ;

  assign pop       = out_valid && out_ready;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = fifo_mem[rd_ptr_q];
  assign out_last  = out_valid && (out_rem_q == CNT_ONE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign r_en      = issue;
  // The counter already points past the last read once it is issued, so
  // the idle address comes from a separate copy of the last issued one.
  assign r_addr    = issue ? addr_q : last_addr_q;

  // Slots committed after this cycle: stored words plus the read in flight,
  // less the word leaving now. pop implies count_q >= 1, so no underflow.
  assign occ = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

  // State register and completion pulse
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Next-state, read issue and done decode
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length == '0) done_d  = 1'b1;
          else              state_d = ISSUE;
        end
      end
      ISSUE: begin
        if ((issue_rem_q != '0) && (occ < 3'd2)) begin
          issue = 1'b1;
          if (issue_rem_q == CNT_ONE) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (out_rem_q == CNT_ONE)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Address and run counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q      <= '0;
      last_addr_q <= '0;
      issue_rem_q <= '0;
      out_rem_q   <= '0;
      inflight_q  <= 1'b0;
    end else begin
      inflight_q <= issue;
      if ((state_q == IDLE) && start) begin
        addr_q      <= base_addr;
        issue_rem_q <= length;
        out_rem_q   <= length;
      end else begin
        if (issue) begin
          addr_q      <= addr_q + ADDR_ONE;
          last_addr_q <= addr_q;
          issue_rem_q <= issue_rem_q - CNT_ONE;
        end
        if (pop) out_rem_q <= out_rem_q - CNT_ONE;
      end
    end
  end

  // Two-entry output FIFO capturing read data one cycle after issue
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      if (inflight_q) begin
        fifo_mem[wr_ptr_q] <= r_data;
        wr_ptr_q           <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= occ[1:0];
    end
  end

endmodule

// File: tb/tb_bram_reader.sv
// Directed bench for bram_reader with a synchronous-read RAM model.
module tb_bram_reader;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int BUDGET = 2000;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   length = '0;
  logic              busy, done, r_en;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data = '0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid, out_last;
  logic              out_ready = 1'b0;

  logic [DATA_W-1:0] ram [DEPTH];
  int checks = 0;
  int errors = 0;
  logic [ADDR_W-1:0] prev_addr = '0;

  bram_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .length(length), .busy(busy), .done(done), .r_en(r_en), .r_addr(r_addr),
    .r_data(r_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // RAM model: one-cycle registered read
  always @(posedge clk) if (r_en) r_data <= ram[r_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int mode, input int c);
    case (mode)
      1:       return (c >= 10);
      2:       return (c % 2 == 0);
      default: return 1'b1;
    endcase
  endfunction

  // mode 0: ready held high; 1: ready low until cycle 10; 2: ready 1,0,1,0...
  task automatic run(input int base, input int len, input int mode, input string tag);
    int c = 0;
    int n_hs = 0;
    int n_ren = 0;
    int ren_before10 = 0;
    int done_cyc = -1;
    int last_hs = -1;
    logic any_busy = 1'b0;
    logic any_valid = 1'b0;
    logic pv = 1'b0, pr = 1'b1, pl = 1'b0;
    logic [DATA_W-1:0] pd = '0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = ADDR_W'(base); length = (ADDR_W+1)'(len);
    out_ready = rdy(mode, 0);
    while (c < BUDGET && done_cyc < 0) begin
      @(negedge clk);
      if (c == 1) check({tag, " busy_c1"}, 32'(busy), 32'(len != 0));
      any_busy  = any_busy | busy;
      any_valid = any_valid | out_valid;
      if (r_en) begin
        check({tag, " r_addr"}, 32'(r_addr), 32'((base + n_ren) % DEPTH));
        if (mode == 0) check({tag, " r_en_cycle"}, 32'(c), 32'(1 + n_ren));
        if (c < 10) ren_before10++;
        n_ren++;
      end else begin
        check({tag, " r_addr_hold"}, 32'(r_addr), 32'(prev_addr));
      end
      prev_addr = r_addr;
      if (pv && !pr) begin
        check({tag, " hold_valid"}, 32'(out_valid), 32'd1);
        check({tag, " hold_data"}, 32'(out_data), 32'(pd));
        check({tag, " hold_last"}, 32'(out_last), 32'(pl));
      end
      if (out_valid && out_ready) begin
        check({tag, " data"}, 32'(out_data), 32'(((base + n_hs) % DEPTH) & 8'hFF));
        check({tag, " last"}, 32'(out_last), 32'(n_hs == len - 1));
        if (mode == 0) check({tag, " hs_cycle"}, 32'(c), 32'(3 + n_hs));
        n_hs++;
        last_hs = c;
      end
      if (done) begin
        done_cyc = c;
        check({tag, " busy_at_done"}, 32'(busy), 32'd0);
      end
      pv = out_valid; pd = out_data; pl = out_last; pr = out_ready;
      @(posedge clk); #1;
      start = 1'b0;
      c++;
      out_ready = rdy(mode, c);
    end
    check({tag, " done_seen"}, 32'(done_cyc >= 0), 32'd1);
    check({tag, " handshakes"}, 32'(n_hs), 32'(len));
    check({tag, " r_en_count"}, 32'(n_ren), 32'(len));
    if (len == 0) begin
      check({tag, " done_cycle"}, 32'(done_cyc), 32'd1);
      check({tag, " busy_never"}, 32'(any_busy), 32'd0);
      check({tag, " valid_never"}, 32'(any_valid), 32'd0);
    end else begin
      check({tag, " done_after_last"}, 32'(done_cyc), 32'(last_hs + 1));
      if (mode == 0) check({tag, " done_cycle"}, 32'(done_cyc), 32'(len + 3));
      if (mode == 1) check({tag, " r_en_before10"}, 32'(ren_before10), 32'd2);
    end
    @(negedge clk);
    check({tag, " done_single"}, 32'(done), 32'd0);
    check({tag, " idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dones;
    for (int i = 0; i < DEPTH; i++) ram[i] = DATA_W'(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst r_en", 32'(r_en), 32'd0);
    check("rst r_addr", 32'(r_addr), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_data", 32'(out_data), 32'd0);
    check("rst out_last", 32'(out_last), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    run(4, 5, 0, "basic");
    run(DEPTH - 2, 4, 0, "wrap");
    run(30, 3, 1, "backpressure");
    run(40, 16, 2, "toggle");
    run(0, 0, 0, "zero_len");
    run(7, DEPTH, 0, "full_sweep");

    // Reset asserted in cycle 5 of a length-10 run
    @(posedge clk); #1;
    start = 1'b1; base_addr = ADDR_W'(20); length = (ADDR_W+1)'(10); out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort r_en", 32'(r_en), 32'd0);
    check("abort r_addr", 32'(r_addr), 32'd0);
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort out_data", 32'(out_data), 32'd0);
    check("abort out_last", 32'(out_last), 32'd0);
    prev_addr = '0;
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort no_done", 32'(dones), 32'd0);
    run(100, 3, 0, "after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
